// File: rtl/pulse_gen_defs.sv
// Shared constants and types for the multi-channel load pulse generator.
package pulse_gen_defs;

   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_RISE = 2'b01;
   localparam logic [1:0] MODE_FALL = 2'b10;
   localparam logic [1:0] MODE_BOTH = 2'b11;

   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      FIRST_WAIT = 2'b01,
      REPEAT     = 2'b10
   } rep_state_e;

   // Bits needed to count 0..max_val-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val > 1) ? $clog2(max_val) : 1;
   endfunction

endpackage

// File: rtl/pulse_gen_chan.sv
// One trigger channel: synchroniser, debounce, edge select, pulse stretcher and
// auto-repeat FSM.
module pulse_gen_chan
   import pulse_gen_defs::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned PULSE_WIDTH     = 1,
   parameter int unsigned REPEAT_DELAY    = 1000,
   parameter int unsigned REPEAT_PERIOD   = 250
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       trigger,
   input  logic [1:0] mode,
   input  logic       rep_en,
   output logic       load,
   output logic       level
);

   localparam int unsigned DbW = cnt_width(DEBOUNCE_CYCLES);
   localparam int unsigned PwW = cnt_width(PULSE_WIDTH);
   localparam int unsigned RcW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ?
                                           REPEAT_DELAY : REPEAT_PERIOD);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   logic [DbW-1:0]         db_cnt_q;
   logic                   level_q, level_prev_q;
   logic                   rise, fall, edge_event;
   logic [PwW-1:0]         pcnt_q;
   logic                   load_q;
   rep_state_e             state_q, state_d;
   logic [RcW-1:0]         rcnt_q, rcnt_d;
   logic [1:0]             armed_mode_q, armed_mode_d;
   logic                   rep_mode, held, rep_exit, rcnt_done, pulse_start;

   assign sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync_q       <= '0;
         db_cnt_q     <= '0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
      end else begin
         sync_q       <= {sync_q[SYNC_STAGES-2:0], trigger};
         level_prev_q <= level_q;
         if (sync == level_q) begin
            db_cnt_q <= '0;
         end else if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
            level_q  <= sync;
            db_cnt_q <= '0;
         end else begin
            db_cnt_q <= db_cnt_q + DbW'(1);
         end
      end
   end

   assign rise = level_q & ~level_prev_q;
   assign fall = ~level_q & level_prev_q;

   always_comb begin
      edge_event = 1'b0;
      case (mode)
         MODE_RISE: edge_event = rise;
         MODE_FALL: edge_event = fall;
         MODE_BOTH: edge_event = rise | fall;
         default:   edge_event = 1'b0;
      endcase
   end

   // Repeat FSM: the mode in force when armed is kept so any change exits.
   assign rep_mode  = (mode == MODE_RISE) || (mode == MODE_FALL);
   assign held      = (armed_mode_q == MODE_RISE) ? level_q : ~level_q;
   assign rep_exit  = !rep_en || (mode != armed_mode_q) || !held;
   assign rcnt_done = (state_q == FIRST_WAIT) ? (rcnt_q == RcW'(REPEAT_DELAY - 1)) :
                                                (rcnt_q == RcW'(REPEAT_PERIOD - 1));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         rcnt_q       <= '0;
         armed_mode_q <= MODE_OFF;
      end else begin
         state_q      <= state_d;
         rcnt_q       <= rcnt_d;
         armed_mode_q <= armed_mode_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      rcnt_d       = rcnt_q;
      armed_mode_d = armed_mode_q;
      unique case (state_q)
         IDLE: begin
            if (edge_event && rep_en && rep_mode) begin
               state_d      = FIRST_WAIT;
               rcnt_d       = '0;
               armed_mode_d = mode;
            end
         end
         FIRST_WAIT, REPEAT: begin
            if (rep_exit) begin
               state_d = IDLE;
            end else if (rcnt_done) begin
               state_d = REPEAT;
               rcnt_d  = '0;
            end else begin
               rcnt_d = rcnt_q + RcW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pulse_start = edge_event | ((state_q != IDLE) && !rep_exit && rcnt_done);
   end

   // A start while load is high restarts the count, stretching the pulse.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         load_q <= 1'b0;
         pcnt_q <= '0;
      end else if (pulse_start) begin
         load_q <= 1'b1;
         pcnt_q <= '0;
      end else if (load_q) begin
         if (pcnt_q == PwW'(PULSE_WIDTH - 1)) begin
            load_q <= 1'b0;
         end else begin
            pcnt_q <= pcnt_q + PwW'(1);
         end
      end
   end

   assign load  = load_q;
   assign level = level_q;

endmodule

// File: rtl/multi_pulse_gen.sv
// N_CH independent trigger-to-load-pulse channels; this level is wiring only.
module multi_pulse_gen
   import pulse_gen_defs::*;
#(
   parameter int unsigned N_CH            = 4,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned PULSE_WIDTH     = 1,
   parameter int unsigned REPEAT_DELAY    = 1000,
   parameter int unsigned REPEAT_PERIOD   = 250
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic [N_CH-1:0]   trigger,
   input  logic [2*N_CH-1:0] mode,
   input  logic [N_CH-1:0]   rep_en,
   output logic [N_CH-1:0]   load,
   output logic [N_CH-1:0]   level
);

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      pulse_gen_chan #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .PULSE_WIDTH    (PULSE_WIDTH),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_chan (
         .clock  (clock),
         .resetn (resetn),
         .trigger(trigger[i]),
         .mode   (mode[2*i +: 2]),
         .rep_en (rep_en[i]),
         .load   (load[i]),
         .level  (level[i])
      );
   end

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Scoreboard bench: stimulus queues expected pulses and level samples, the
// monitor matches them against the two DUT instances.
module tb_multi_pulse_gen;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic [1:0] trigger = '0;
   logic [3:0] mode = '0;
   logic [1:0] rep_en = '0;
   logic [1:0] load, level;
   logic [0:0] trigger_b = '0;
   logic [1:0] mode_b = '0;
   logic [0:0] rep_en_b = '0;
   logic [0:0] load_b, level_b;

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   multi_pulse_gen #(
      .N_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .PULSE_WIDTH(3),
      .REPEAT_DELAY(10), .REPEAT_PERIOD(6)
   ) dut (
      .clock(clock), .resetn(resetn), .trigger(trigger), .mode(mode),
      .rep_en(rep_en), .load(load), .level(level)
   );

   // Wide-pulse instance for the retrigger-extension case (monitor channel 2).
   multi_pulse_gen #(
      .N_CH(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .PULSE_WIDTH(8),
      .REPEAT_DELAY(10), .REPEAT_PERIOD(6)
   ) dut_b (
      .clock(clock), .resetn(resetn), .trigger(trigger_b), .mode(mode_b),
      .rep_en(rep_en_b), .load(load_b), .level(level_b)
   );

   typedef struct { int ch; int start; int width; } pulse_t;
   typedef struct { int cyc; int ch; bit is_load; bit val; } lvl_t;

   pulse_t exp_q[$];
   lvl_t   lvl_q[$];
   bit     pused[128];
   bit     lused[128];
   int     checks = 0;
   int     failures = 0;
   bit     done = 1'b0;
   bit     final_done = 1'b0;
   int     start_at[3];
   int     want_w[3];
   bit     have_w[3];
   logic [2:0] prev = '0;

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic push_pulse(input int ch, input int start, input int width);
      pulse_t p;
      p.ch = ch; p.start = start; p.width = width;
      exp_q.push_back(p);
   endtask

   task automatic push_lvl(input int at, input int ch, input bit is_load, input bit val);
      lvl_t l;
      l.cyc = at; l.ch = ch; l.is_load = is_load; l.val = val;
      lvl_q.push_back(l);
   endtask

   always @(negedge clock) begin : monitor
      logic [2:0] ld;
      logic [2:0] lv;
      logic       got;
      int         idx;
      int         w;
      int         left;
      ld = {load_b, load};
      lv = {level_b, level};
      for (int c = 0; c < 3; c++) begin
         if (ld[c] && !prev[c]) begin
            start_at[c] = cyc;
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++)
               if (idx < 0 && !pused[i] && exp_q[i].ch == c) idx = i;
            checks++;
            if (idx < 0) begin
               failures++;
               have_w[c] = 1'b0;
               $display("FAIL spurious_pulse ch%0d start=%0d required=no pulse", c, cyc);
            end else begin
               pused[idx] = 1'b1;
               if (exp_q[idx].start != cyc) begin
                  failures++;
                  $display("FAIL pulse_start ch%0d got=%0d required=%0d", c, cyc,
                           exp_q[idx].start);
               end
               want_w[c] = exp_q[idx].width;
               have_w[c] = 1'b1;
            end
         end else if (!ld[c] && prev[c] && have_w[c]) begin
            w = cyc - start_at[c];
            checks++;
            if (w != want_w[c]) begin
               failures++;
               $display("FAIL pulse_width ch%0d start=%0d got=%0d required=%0d", c,
                        start_at[c], w, want_w[c]);
            end
            have_w[c] = 1'b0;
         end
      end
      prev = ld;
      for (int i = 0; i < lvl_q.size(); i++) begin
         if (!lused[i] && lvl_q[i].cyc <= cyc) begin
            lused[i] = 1'b1;
            checks++;
            got = lvl_q[i].is_load ? ld[lvl_q[i].ch] : lv[lvl_q[i].ch];
            if (lvl_q[i].cyc < cyc) begin
               failures++;
               $display("FAIL stale_sample ch%0d at=%0d now=%0d", lvl_q[i].ch,
                        lvl_q[i].cyc, cyc);
            end else if (got !== lvl_q[i].val) begin
               failures++;
               $display("FAIL %s ch%0d cyc=%0d got=%b required=%b",
                        lvl_q[i].is_load ? "load_value" : "level_value",
                        lvl_q[i].ch, cyc, got, lvl_q[i].val);
            end
         end
      end
      if (done && !final_done) begin
         left = 0;
         for (int i = 0; i < exp_q.size(); i++) if (!pused[i]) left++;
         for (int i = 0; i < lvl_q.size(); i++) if (!lused[i]) left++;
         checks++;
         if (left != 0) begin
            failures++;
            $display("FAIL leftover_expectations got=%0d required=0", left);
         end
         final_done = 1'b1;
      end
   end

   initial begin : stim
      int k;
      int t0;
      int s;
      // Reset state while resetn is held low.
      push_lvl(1, 0, 0, 0); push_lvl(1, 0, 1, 0); push_lvl(2, 1, 0, 0); push_lvl(2, 1, 1, 0);
      tick(3);
      resetn = 1'b1;

      // Basic rising pulse, no repeat; release gives no pulse.
      mode[1:0] = 2'b01; trigger[0] = 1'b1; k = cyc + 1;
      push_lvl(k + 4, 0, 0, 0); push_lvl(k + 5, 0, 0, 1); push_pulse(0, k + 6, 3);
      tick(20);
      trigger[0] = 1'b0; k = cyc + 1;
      push_lvl(k + 4, 0, 0, 1); push_lvl(k + 5, 0, 0, 0);
      tick(15);

      // Debounce: 3-cycle glitches never move level, then a real press.
      for (int g = 0; g < 5; g++) begin
         trigger[0] = 1'b1; tick(3);
         trigger[0] = 1'b0; push_lvl(cyc + 3, 0, 0, 0); tick(3);
      end
      trigger[0] = 1'b1; k = cyc + 1;
      push_lvl(k + 5, 0, 0, 1); push_pulse(0, k + 6, 3);
      tick(10);
      trigger[0] = 1'b0;
      tick(15);

      // Auto-repeat while held 40 cycles.
      rep_en[0] = 1'b1; trigger[0] = 1'b1; k = cyc + 1; t0 = k + 6;
      push_pulse(0, t0, 3);      push_pulse(0, t0 + 10, 3); push_pulse(0, t0 + 16, 3);
      push_pulse(0, t0 + 22, 3); push_pulse(0, t0 + 28, 3); push_pulse(0, t0 + 34, 3);
      tick(40);
      trigger[0] = 1'b0; k = cyc + 1;
      push_lvl(k + 5, 0, 0, 0);
      tick(30);
      rep_en[0] = 1'b0;

      // Both edges on ch1, ch0 off with identical stimulus.
      mode = 4'b1100; trigger = 2'b11; k = cyc + 1;
      push_lvl(k + 5, 0, 0, 1); push_lvl(k + 5, 1, 0, 1); push_pulse(1, k + 6, 3);
      tick(12);
      trigger = 2'b00;
      push_pulse(1, k + 18, 3); push_lvl(k + 17, 0, 0, 0); push_lvl(k + 18, 0, 1, 0);
      tick(15);

      // Reset during the second load cycle, then recovery with trigger held.
      mode = 4'b0001; rep_en = 2'b01; trigger[0] = 1'b1; k = cyc + 1; s = k + 6;
      push_pulse(0, s, 1);
      tick(8);
      resetn = 1'b0;
      push_lvl(s + 1, 0, 0, 0); push_lvl(s + 1, 0, 1, 0);
      tick(2);
      resetn = 1'b1; k = cyc + 1; t0 = k + 6;
      push_pulse(0, t0, 3); push_pulse(0, t0 + 10, 3); push_pulse(0, t0 + 16, 3);
      tick(20);
      trigger[0] = 1'b0;
      push_lvl(k + 25, 0, 0, 0);
      tick(30);
      rep_en = 2'b00; mode = 4'b0000;

      // Retrigger extension on the 8-cycle instance: 5 + 8 = 13 cycles.
      mode_b = 2'b11; trigger_b = 1'b1; k = cyc + 1;
      push_lvl(k + 5, 2, 0, 1); push_lvl(k + 10, 2, 0, 0); push_pulse(2, k + 6, 13);
      push_lvl(k + 12, 2, 1, 1);
      tick(5);
      trigger_b = 1'b0;
      tick(30);

      done = 1'b1;
      tick(3);
      if (!final_done) tick(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multi_pulse_gen.md
Name: multi_pulse_gen

Overview:
- Parametrised, multi-channel successor to the single-channel one-shot load generator.
- Each channel does the following, in order:
  - synchronises an asynchronous trigger (push-button, switch or external strobe);
  - debounces it;
  - detects a selectable edge;
  - emits a load pulse PULSE_WIDTH cycles wide.
- Optional auto-repeat while the trigger is held.
- Sits between board I/O and the soft-CPU step/load/interrupt inputs.

Parameters:
- N_CH, 4: number of independent channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- DEBOUNCE_CYCLES, 16: stable cycles required before the debounced level changes (≥1).
- PULSE_WIDTH, 1: load pulse width in clock cycles (≥1).
- REPEAT_DELAY, 1000: cycles from first pulse start to first repeat pulse start (> PULSE_WIDTH).
- REPEAT_PERIOD, 250: cycles between subsequent repeat pulse starts (> PULSE_WIDTH).

Ports:
- clock, in, 1: system clock, rising edge.
- resetn, in, 1: asynchronous, active-low reset.
- trigger, in, N_CH: raw asynchronous inputs.
- mode, in, 2*N_CH: per-channel edge mode. Channel i uses bits [2i+1:2i]. Encoding: 00 off, 01 rising, 10 falling, 11 both.
- rep_en, in, N_CH: per-channel auto-repeat enable.
- load, out, N_CH: registered pulse outputs.
- level, out, N_CH: registered debounced level.

Behaviour:
- Reset (resetn=0, asynchronous) clears the following immediately; mid-pulse or mid-repeat in-flight activity is discarded:
  - sync chains, debounced level, counters and FSMs all go to 0/IDLE;
  - load=0, level=0.
- Synchroniser:
  - s[0] samples trigger on each edge; the output of s[SYNC_STAGES-1] is sync.
- Debounce counter:
  - if sync==level, cnt<=0;
  - else, if cnt==DEBOUNCE_CYCLES-1, then level<=sync and cnt<=0;
  - else, cnt<=cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes level.
- Edge event:
  - level_q is level delayed one cycle.
  - rise = level & ~level_q; fall = ~level & level_q.
  - event = (mode==01 & rise) | (mode==10 & fall) | (mode==11 & (rise|fall)). Mode 00 never fires.
- Latency: trigger change sampled at edge k → level changes at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1 → load rises at edge k+SYNC_STAGES+DEBOUNCE_CYCLES.
- Pulse counter:
  - a start sets load=1 for exactly PULSE_WIDTH cycles;
  - a new start while load is high restarts the count, so the pulse is extended, never doubled.
- Repeat FSM, per channel:
  - IDLE: on event → start pulse. If rep_en=1 and mode is 01/10, go to FIRST_WAIT with rcnt=0; otherwise stay in IDLE.
  - FIRST_WAIT: rcnt increments each cycle. If rcnt==REPEAT_DELAY-1 → start pulse, rcnt=0, go to REPEAT.
  - REPEAT: if rcnt==REPEAT_PERIOD-1 → start pulse, rcnt=0.
  - Held condition: level==1 for mode 01, level==0 for mode 10.
  - Exit: in FIRST_WAIT/REPEAT, loss of the held condition, rep_en=0, or any mode change returns the FSM to IDLE in the same cycle. The pulse in progress completes normally.
  - Mode 11 never auto-repeats.
- Pulse start timing: first pulse starts at edge t0; repeats start at t0+REPEAT_DELAY, then every REPEAT_PERIOD.
- Channels are fully independent; simultaneous events on several channels all fire in the same cycle.
- Power-up/reset with trigger held high: level rises after the normal latency, and rising/both modes emit one pulse. This is intentional: it matches the single-channel block.
- Counter widths: $clog2 of the respective maximum, minimum 1 bit; no wrap-around is possible by construction.

Decomposition:
- Shared package/header pulse_gen_defs:
  - mode constants MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11;
  - repeat-state encoding IDLE=2'b00, FIRST_WAIT=2'b01, REPEAT=2'b10.
- One sub-module, pulse_gen_chan: a single channel (sync, debounce, edge, pulse, repeat FSM).
- multi_pulse_gen generates N_CH instances and does only the wiring.

Test Plan (N_CH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, PULSE_WIDTH=3, REPEAT_DELAY=10, REPEAT_PERIOD=6):
- Basic rising pulse:
  - Stimulus: ch0 mode=01, rep_en=0; trigger 0→1 sampled at edge k, held 20 cycles.
  - Response: level high from edge k+5; load high for exactly 3 cycles starting edge k+6; no further pulses; release → no pulse.
- Debounce:
  - Stimulus: 3-cycle high glitches separated by 3-cycle lows, repeated 5 times.
  - Response: level and load stay 0.
  - Then hold high ≥4 cycles → exactly one pulse.
- Auto-repeat:
  - Stimulus: ch0 mode=01, rep_en=1, held 40 cycles.
  - Response: pulse starts at t0, t0+10, t0+16, t0+22, t0+28, t0+34.
  - Release → FSM IDLE, no pulse afterwards; the last pulse completes its full 3 cycles.
- Both edges / independence:
  - Stimulus: ch1 mode=11, high pulse of 12 cycles; ch0 mode=00 with identical stimulus.
  - Response: ch1 gives two 3-cycle pulses, 12 cycles apart; ch0 load stays 0 while level tracks.
- Reset mid-operation:
  - Stimulus: assert resetn=0 during the 2nd load cycle with rep_en=1.
  - Response: load, level, FSM cleared asynchronously.
  - After release with trigger still high: one pulse after the normal latency, then repeats resume per timing.
- Retrigger extension:
  - Stimulus: PULSE_WIDTH=8 (override), mode=11, trigger high for 5 stable cycles.
  - Response: single continuous load of 13 cycles (rise start plus restart at fall); never two separate pulses.
